// File: rtl/io_bus_sequencer.sv
`timescale 1ns/1ps
// External I/O bus master: byte-lane selects, programmable
// setup/strobe/hold timing, wait states, timeout and misalignment errors.
module io_bus_sequencer #(
  parameter int DATA_BYTES    = 2,
  parameter int ADDR_WIDTH    = 16,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int TIMEOUT       = 255
) (
  input  logic                                      clock,
  input  logic                                      notReset,
  input  logic                                      req,
  input  logic                                      req_write,
  input  logic                                      req_word,
  input  logic [ADDR_WIDTH-1:0]                     req_addr,
  input  logic [8*DATA_BYTES-1:0]                   req_wdata,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      error,
  output logic [8*DATA_BYTES-1:0]                   rdata,
  input  logic                                      in_ready,
  inout  wire  [ADDR_WIDTH-$clog2(DATA_BYTES)-1:0]  out_address,
  inout  wire  [8*DATA_BYTES-1:0]                   inout_data,
  output logic                                      out_rd_n,
  output logic                                      out_wr_n,
  output logic [DATA_BYTES-1:0]                     out_cs_n
);

  localparam int W  = 8 * DATA_BYTES;
  localparam int L  = $clog2(DATA_BYTES);
  localparam int M1 = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int M2 = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
  localparam int MX = (M1 > M2) ? M1 : M2;
  localparam int CW = $clog2(MX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [W-1:0]          wdata_q, wdata_d;
  logic [W-1:0]          rdata_q, rdata_d;
  logic                  write_q, write_d;
  logic                  word_q, word_d;
  logic                  err_q, err_d;
  logic                  mis_q, mis_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  rd_n_q, rd_n_d;
  logic                  wr_n_q, wr_n_d;
  logic                  abus_q, abus_d;
  logic [DATA_BYTES-1:0] cs_n_q, cs_n_d;
  logic [DATA_BYTES-1:0] doe_q, doe_d;
  logic [DATA_BYTES-1:0] mask_d;
  logic                  strobe_d;
  logic [7:0]            lane_byte;
  logic [W-1:0]          rd_sel;

  always_comb begin
    lane_byte = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (addr_q[L-1:0] == L'(i)) lane_byte = inout_data[8*i +: 8];
    end
    rd_sel = word_q ? inout_data : W'(lane_byte);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    write_d = write_q;
    word_d  = word_q;
    err_d   = err_q;
    mis_d   = 1'b0;
    done_d  = 1'b0;
    error_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = req_addr;
          write_d = req_write;
          word_d  = req_word;
          wdata_d = req_word ? req_wdata : {DATA_BYTES{req_wdata[7:0]}};
          err_d   = 1'b0;
          if (req_word && req_addr[L-1:0] != '0) begin
            mis_d = 1'b1;
          end else begin
            state_d = S_SETUP;
            cnt_d   = CW'(SETUP_CYCLES - 1);
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = CW'(STROBE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (in_ready) begin
          state_d = S_HOLD;
          cnt_d   = CW'(HOLD_CYCLES - 1);
          if (!write_q) rdata_d = rd_sel;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (in_ready) begin
          state_d = S_HOLD;
          cnt_d   = CW'(HOLD_CYCLES - 1);
          if (!write_q) rdata_d = rd_sel;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_HOLD;
          cnt_d   = CW'(HOLD_CYCLES - 1);
          err_d   = 1'b1;
          if (!write_q) rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          error_d = err_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // a misaligned request reports one cycle after it was latched
    done_d  = done_d | mis_q;
    error_d = error_d | mis_q;
  end

  // bus pins are registered from the next-state decode
  always_comb begin
    for (int i = 0; i < DATA_BYTES; i++) begin
      mask_d[i] = word_d | (addr_d[L-1:0] == L'(i));
    end
    abus_d   = (state_d != S_IDLE);
    strobe_d = (state_d == S_STROBE) || (state_d == S_WAIT);
    rd_n_d   = ~(strobe_d & ~write_d);
    wr_n_d   = ~(strobe_d & write_d);
    cs_n_d   = abus_d ? ~mask_d : '1;
    doe_d    = (abus_d & write_d) ? mask_d : '0;
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      word_q  <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      abus_q  <= 1'b0;
      cs_n_q  <= '1;
      doe_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      word_q  <= word_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      done_q  <= done_d;
      error_q <= error_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      abus_q  <= abus_d;
      cs_n_q  <= cs_n_d;
      doe_q   <= doe_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign error    = error_q;
  assign rdata    = rdata_q;
  assign out_rd_n = rd_n_q;
  assign out_wr_n = wr_n_q;
  assign out_cs_n = cs_n_q;

  assign out_address = abus_q ? addr_q[ADDR_WIDTH-1:L] : 'z;

  for (genvar g = 0; g < DATA_BYTES; g++) begin : g_lane
    assign inout_data[8*g +: 8] = doe_q[g] ? wdata_q[8*g +: 8] : 8'hzz;
  end

endmodule

// File: tb/tb_io_bus_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for io_bus_sequencer: 16-bit instance with
// TIMEOUT=4 plus a 32-bit instance for back-to-back requests.
module tb_io_bus_sequencer;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          strb;
    int          k;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          strb_cnt = 0;
  exp_t        q[$];

  logic        req, rw, rword, rdy;
  logic [15:0] raddr, rwd;
  logic        busy, done, err, rd_n, wr_n;
  logic [15:0] rdata;
  logic [1:0]  cs_n;
  wire  [14:0] abus;
  wire  [15:0] dbus;
  logic [15:0] dev_val;
  logic        lane0_drv;

  logic        req4, rdy4;
  logic [15:0] addr4;
  logic [31:0] wd4, rdata4;
  logic        busy4, done4, err4, rd4_n, wr4_n;
  logic [3:0]  cs4_n;
  wire  [13:0] abus4;
  wire  [31:0] dbus4;

  assign dbus[15:8] = !rd_n ? dev_val[15:8] : 8'hzz;
  assign dbus[7:0]  = !rd_n ? dev_val[7:0] : (lane0_drv ? 8'hC3 : 8'hzz);
  assign dbus4      = !rd4_n ? 32'hCAFEF00D : 32'hzzzzzzzz;

  io_bus_sequencer #(.TIMEOUT(4)) u_dut (
    .clock(clk), .notReset(nrst), .req(req), .req_write(rw),
    .req_word(rword), .req_addr(raddr), .req_wdata(rwd),
    .busy(busy), .done(done), .error(err), .rdata(rdata),
    .in_ready(rdy), .out_address(abus), .inout_data(dbus),
    .out_rd_n(rd_n), .out_wr_n(wr_n), .out_cs_n(cs_n)
  );

  io_bus_sequencer #(.DATA_BYTES(4)) u_dut4 (
    .clock(clk), .notReset(nrst), .req(req4), .req_write(1'b0),
    .req_word(1'b1), .req_addr(addr4), .req_wdata(wd4),
    .busy(busy4), .done(done4), .error(err4), .rdata(rdata4),
    .in_ready(rdy4), .out_address(abus4), .inout_data(dbus4),
    .out_rd_n(rd4_n), .out_wr_n(wr4_n), .out_cs_n(cs4_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: counts strobe-low cycles and scores each done pulse
  always @(negedge clk) begin
    if (!nrst) begin
      strb_cnt = 0;
    end else begin
      if (!rd_n || !wr_n) strb_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rdata", 32'(rdata), 32'(e.rdata));
          chk("error", 32'(err), 32'(e.err));
          chk("latency", cyc - e.k, e.lat);
          chk("strobe_cycles", strb_cnt, e.strb);
          chk("busy_in_done", 32'(busy), 32'd0);
        end
        strb_cnt = 0;
      end
    end
  end

  task automatic issue(input logic w, input logic wd,
                       input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] er, input logic ee,
                       input int lat, input int strb, input bit push);
    exp_t e;
    @(negedge clk);
    req = 1'b1; rw = w; rword = wd; raddr = a; rwd = d;
    @(posedge clk); #1;
    req = 1'b0;
    e.rdata = er; e.err = ee; e.lat = lat; e.strb = strb; e.k = cyc;
    if (push) q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k4, nd;
    int dpos[2];
    nrst = 1'b0; req = 1'b0; rw = 1'b0; rword = 1'b0;
    raddr = '0; rwd = '0; rdy = 1'b1; dev_val = '0; lane0_drv = 1'b0;
    req4 = 1'b0; addr4 = '0; wd4 = '0; rdy4 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_strobes", {30'd0, rd_n, wr_n}, 32'd3);
    chk("rst_cs_n", 32'(cs_n), 32'h3);
    nrst = 1'b1;

    // word read
    dev_val = 16'hBEEF;
    issue(1'b0, 1'b1, 16'h0010, 16'h0, 16'hBEEF, 1'b0, 4, 2, 1'b1);
    @(negedge clk); @(negedge clk);
    chk("wr_rd_addr", 32'(abus), 32'h0008);
    chk("wr_rd_cs", 32'(cs_n), 32'h0);
    chk("wr_rd_rdn", 32'(rd_n), 0);
    drain();

    // byte write to lane 1
    lane0_drv = 1'b1;
    issue(1'b1, 1'b0, 16'h0013, 16'h005A, 16'hBEEF, 1'b0, 4, 2, 1'b1);
    @(negedge clk); @(negedge clk);
    chk("bw_cs", 32'(cs_n), 32'h1);
    chk("bw_lane1", 32'(dbus[15:8]), 32'h5A);
    chk("bw_lane0_free", 32'(dbus[7:0]), 32'hC3);
    chk("bw_wrn", 32'(wr_n), 0);
    chk("bw_rdn", 32'(rd_n), 1);
    drain();
    lane0_drv = 1'b0;

    // byte reads, both lanes
    issue(1'b0, 1'b0, 16'h0011, 16'h0, 16'h00BE, 1'b0, 4, 2, 1'b1);
    drain();
    issue(1'b0, 1'b0, 16'h0012, 16'h0, 16'h00EF, 1'b0, 4, 2, 1'b1);
    @(negedge clk); @(negedge clk);
    chk("br_cs_lane0", 32'(cs_n), 32'h2);
    drain();

    // misaligned word: no bus activity, rdata kept
    issue(1'b0, 1'b1, 16'h0001, 16'h0, 16'h00EF, 1'b1, 1, 0, 1'b1);
    @(negedge clk);
    chk("mis_cs", 32'(cs_n), 32'h3);
    chk("mis_rdn", 32'(rd_n), 1);
    chk("mis_busy", 32'(busy), 0);
    drain();

    // three wait states
    dev_val = 16'h1357;
    rdy = 1'b0;
    issue(1'b0, 1'b1, 16'h0030, 16'h0, 16'h1357, 1'b0, 7, 5, 1'b1);
    repeat (5) @(posedge clk);
    #1 rdy = 1'b1;
    drain();

    // reset during strobe
    dev_val = 16'h2468;
    issue(1'b0, 1'b1, 16'h0050, 16'h0, 16'h0, 1'b0, 0, 0, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("pre_rst_rdn", 32'(rd_n), 0);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_rdata", 32'(rdata), 0);
    chk("mid_rst_strobes", {30'd0, rd_n, wr_n}, 32'd3);
    chk("mid_rst_cs", 32'(cs_n), 32'h3);
    @(negedge clk); @(negedge clk);
    nrst = 1'b1;
    repeat (6) @(negedge clk);

    // timeout
    rdy = 1'b0;
    issue(1'b0, 1'b1, 16'h0040, 16'h0, 16'h0000, 1'b1, 8, 6, 1'b1);
    drain();
    chk("abort_rdn", 32'(rd_n), 1);
    rdy = 1'b1;

    // recovery read
    dev_val = 16'h1234;
    issue(1'b0, 1'b1, 16'h0020, 16'h0, 16'h1234, 1'b0, 4, 2, 1'b1);
    drain();

    // 32-bit instance, req held high
    addr4 = 16'h0020;
    @(negedge clk);
    req4 = 1'b1;
    @(posedge clk); #1;
    k4 = cyc; nd = 0; dpos[0] = -1; dpos[1] = -1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (cyc - k4 == 1) begin
        chk("b2b_addr", 32'(abus4), 32'h0008);
        chk("b2b_cs", 32'(cs4_n), 32'h0);
      end
      if (done4) begin
        if (nd < 2) dpos[nd] = cyc - k4;
        nd++;
        chk("b2b_rdata", rdata4, 32'hCAFEF00D);
        chk("b2b_busy", 32'(busy4), 0);
      end
    end
    req4 = 1'b0;
    chk("b2b_count", nd, 2);
    chk("b2b_done0", dpos[0], 4);
    chk("b2b_done1", dpos[1], 9);
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bus_sequencer.md
# io_bus_sequencer

Parametrised external I/O bus master. It generalises the fixed 16-bit I/O interface to DATA_BYTES byte lanes and programmable setup/strobe/hold timing, and adds device wait states via `in_ready`, a wait timeout, and misalignment/timeout error reporting. It sits between the CPU datapath request logic and the off-chip device bus. All bus outputs come from posedge flops, so they are glitch-free.

## Interface
- `DATA_BYTES`, 2: byte lanes on the device bus; power of two, ≥2. Let W = 8·DATA_BYTES and L = log2(DATA_BYTES).
- `ADDR_WIDTH`, 16: width of the byte address.
- `SETUP_CYCLES`, 1: cycles with address/chip-select valid before the strobe; ≥1.
- `STROBE_CYCLES`, 2: minimum strobe-low cycles; ≥1.
- `HOLD_CYCLES`, 1: cycles after the strobe rises with address, chip-select and write data held; ≥1.
- `TIMEOUT`, 255: maximum WAIT cycles before the access is aborted; ≥1.

Ports:
- `clock`  in  1  system clock; all state changes on posedge.
- `notReset`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request; accepted only when `busy`=0.
- `req_write`  in  1  1 = write, 0 = read.
- `req_word`  in  1  1 = full W-bit access, 0 = single byte.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  W  write data; for a byte access, bits [7:0] are used.
- `busy`  out  1  access in progress.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  valid with `done`: misaligned word access or timeout.
- `rdata`  out  W  read result; byte reads are zero-extended into [7:0].
- `in_ready`  in  1  device ready; 0 inserts wait states.
- `out_address`  inout  ADDR_WIDTH−L  word address; Z when idle.
- `inout_data`  inout  W  device data bus.
- `out_rd_n`, `out_wr_n`  out  1  active-low strobes.
- `out_cs_n`  out  DATA_BYTES  active-low per-lane chip selects.

## Operation
- States: IDLE, SETUP, STROBE, WAIT, HOLD. `busy` = (state ≠ IDLE).
- IDLE with `req`=1 at posedge:
  - Latch the address, data and mode.
  - If `req_word`=1 and `req_addr[L-1:0]`≠0, it is misaligned. The state stays IDLE, and `done`=`error`=1 in the next cycle. No bus activity. `rdata` is unchanged.
  - Otherwise go to SETUP and load the cycle counter.
- Lane selection:
  - Word access: every `out_cs_n` bit is 0.
  - Byte access: only lane `req_addr[L-1:0]` has its `out_cs_n` bit at 0.
- `out_address` = latched `addr[ADDR_WIDTH-1:L]`. It is driven in SETUP, STROBE, WAIT and HOLD, and is Z otherwise.
- Write: `inout_data` drives the selected lanes from SETUP through the end of HOLD. For a byte write, `wdata[7:0]` is placed on the selected lane. Unselected lanes and all reads leave `inout_data` at Z.
- SETUP lasts SETUP_CYCLES cycles, with strobes high, then goes to STROBE.
- STROBE: `out_rd_n` (read) or `out_wr_n` (write) is 0 for STROBE_CYCLES cycles. On the last cycle's edge, `in_ready` is sampled: 1 goes to HOLD, 0 goes to WAIT.
- WAIT: the strobe stays low and the timeout counter increments every cycle.
  - `in_ready`=1 at an edge: go to HOLD.
  - After TIMEOUT cycles with no ready: go to HOLD and set the error flag.
- Read capture: on the edge that leaves STROBE/WAIT for HOLD, `rdata` ← selected data.
  - Word: `inout_data`.
  - Byte: {0, lane byte}.
  - Timeout: `rdata` = 0.
- HOLD lasts HOLD_CYCLES cycles with strobes high, then goes to IDLE with `done`=1 (and `error` if flagged) for exactly one cycle.
- A `req` present during the `done` cycle is accepted, which gives back-to-back accesses. `req` while `busy`=1 is ignored, not queued.
- Counters are sized to fit max(SETUP, STROBE, HOLD, TIMEOUT); no wrap is possible.
- Reset (async, at any time, including mid-access):
  - State → IDLE.
  - `busy`, `done` and `error` = 0.
  - `rdata` = 0.
  - `out_rd_n` = `out_wr_n` = 1.
  - `out_cs_n` all 1s.
  - `out_address` and `inout_data` = Z.
  - The aborted access produces no `done`.

## Timing
- Acceptance at edge k. With ready and no waits, `done`=1 in cycle k+S+T+H to k+S+T+H+1, where S, T, H = SETUP, STROBE, HOLD cycles.
  - Defaults: `done` at edge k+4. Strobe low from edge k+1 to k+3.
- Each WAIT cycle adds exactly 1 cycle. Timeout adds exactly TIMEOUT cycles.
- Misaligned request: `done`/`error` at edge k+1.
- `in_ready` is assumed synchronous to `clock`; the device side synchronises it.
- Address and chip selects are stable ≥SETUP_CYCLES cycles before the strobe falls and ≥HOLD_CYCLES cycles after it rises.

## Test plan
- Word read: defaults, addr 0x0010, device drives 0xBEEF, `in_ready`=1. Expect `out_address`=0x0008, `out_cs_n`=00, `out_rd_n` low for 2 cycles, `done` at k+4, `rdata`=0xBEEF, `error`=0.
- Byte write: addr 0x0013, wdata 0x005A. Expect `out_cs_n`=01 (lane 1 low), `inout_data`[15:8]=0x5A, [7:0]=Z, `out_wr_n` low for 2 cycles.
- Wait states: `in_ready` held 0 for 3 cycles, then 1. Expect the strobe to stay low 5 cycles total and `done` at k+7.
- Timeout: TIMEOUT=4, `in_ready` stuck 0, read. Expect `done`+`error` at k+8, `rdata`=0, strobes high after abort.
- Misaligned word: addr 0x0001, `req_word`=1. Expect `done`=`error`=1 at k+1, strobes and chip selects never asserted.
- Reset mid-STROBE and back-to-back:
  - Drop `notReset` during STROBE. Expect all outputs at reset values immediately and no `done`.
  - With DATA_BYTES=4, hold `req` asserted. Expect two accesses with the second accepted in the first's `done` cycle.
